// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, LSB first.
//
// Receives frames driven by the matching uart_tx. Each bit lasts 16 pulses of s_tick.
// The start bit is confirmed at mid-bit, and every later bit is sampled at its middle.
// Each completed frame gives one rx_done_tick pulse together with error flags.
//
// Parameters:
//   DBIT        data bits per frame
//   SB_TICK     s_tick count for the stop bit (16/24/32 = 1/1.5/2 stop bits)
//   PARITY_ODD  0 = even parity, 1 = odd; used only with UART_RX_PARITY_EN
//
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, one parity bit is
// expected after the data bits and is checked. When it is undefined, frames carry no
// parity bit and parity_err is tied to 0.
//
// Ports:
//   clk           system clock
//   reset_n       synchronous active-low reset
//   s_tick        one-clk enable pulse at 16x the baud rate
//   rx            asynchronous serial input, idle high
//   rx_dout       last received word
//   rx_done_tick  one-clk pulse when a frame completes
//   frame_err     stop bit of the last frame was sampled low
//   parity_err    parity mismatch on the last frame
module uart_rx #(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    // The tick counter must reach 15 for data bits and SB_TICK-1 for the stop bit.
    localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID      = SW'(7);
    localparam logic [SW-1:0] S_BIT_END  = SW'(15);
    localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StStop   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] StParity = 3'd4;
`endif

    logic            rx_meta, rx_s;
    logic [2:0]      state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic            p_q, p_d;        // running XOR of data bits
    logic            pmis_q, pmis_d;  // mismatch latched in the parity state
    logic            perr_q, perr_d;
`else
    logic            unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD[0];
`endif

    // Two-flop synchronizer. The flops reset to the idle level so that reset alone
    // cannot make the receiver see a start bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        p_d     = p_q;
        pmis_d  = pmis_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            StIdle: begin
                // The start edge is taken immediately, without waiting for a tick.
                if (!rx_s) begin
                    s_d     = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            s_d     = '0;
                            n_d     = '0;
`ifdef UART_RX_PARITY_EN
                            p_d     = 1'b0;
`endif
                            state_d = StData;
                        end else begin
                            // The line went high again before mid-bit, so treat it as a glitch.
                            state_d = StIdle;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (s_q == S_BIT_END) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
`ifdef UART_RX_PARITY_EN
                        p_d = p_q ^ rx_s;
`endif
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (s_tick) begin
                    if (s_q == S_BIT_END) begin
                        s_d     = '0;
                        pmis_d  = p_q ^ rx_s ^ PARITY_ODD[0];
                        state_d = StStop;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            StStop: begin
                if (s_tick) begin
                    if (s_q == S_STOP_END) begin
                        dout_d  = b_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = pmis_q;
`endif
                        state_d = StIdle;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p_q     <= 1'b0;
            pmis_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            p_q     <= p_d;
            pmis_q  <= pmis_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_dout      = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx (DBIT=8, SB_TICK=16). The bench acts as the serial transmitter.
// It generates its own s_tick and compares every received frame with hand-computed values.
module tb_uart_rx;

    localparam int unsigned DBIT     = 8;
    localparam int unsigned SB_TICK  = 16;
    localparam int unsigned PAR_ODD  = 0;
    localparam int          TICK_DIV = 26;  // 200 clk is less than 8 ticks
`ifdef UART_RX_PARITY_EN
    localparam int          PB = 1;
`else
    localparam int          PB = 0;
`endif
    // Ticks from entering the start state to frame completion.
    localparam int          FRAME_TICKS = 8 + 16 * (DBIT + PB) + SB_TICK;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            s_tick = 1'b0;
    logic            rx;
    logic [DBIT-1:0] rx_dout;
    logic            rx_done_tick;
    logic            frame_err;
    logic            parity_err;

    typedef struct packed {
        logic [7:0] dout;
        logic       ferr;
        logic       perr;
    } rec_t;

    typedef struct {
        logic [7:0] data;
        bit         stop;
        bit         pflip;
        logic [7:0] exp_dout;
        bit         exp_ferr;
        bit         exp_perr;
    } vec_t;

    rec_t got[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   tick_cnt = 0;

    uart_rx #(
        .DBIT       (DBIT),
        .SB_TICK    (SB_TICK),
        .PARITY_ODD (PAR_ODD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .rx           (rx),
        .rx_dout      (rx_dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    // Free-running 16x baud tick, changed on the falling edge.
    always @(negedge clk) begin
        if (tick_cnt == TICK_DIV - 1) begin
            s_tick   = 1'b1;
            tick_cnt = 0;
        end else begin
            s_tick   = 1'b0;
            tick_cnt = tick_cnt + 1;
        end
    end

    // Capture every completion pulse.
    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) got.push_back('{rx_dout, frame_err, parity_err});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic wait_ticks(input int t);
        repeat (t * TICK_DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input bit pflip);
        rx = 1'b0;
        wait_ticks(16);
        for (int k = 0; k < DBIT; k++) begin
            rx = d[k];
            wait_ticks(16);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ PAR_ODD[0] ^ pflip;
        wait_ticks(16);
`endif
        if (stop) begin
            rx = 1'b1;
            wait_ticks(16);
        end else begin
            // Hold the low stop level only past the mid-bit sample. This way the receiver
            // sees the line high again before a false start could be confirmed.
            rx = 1'b0;
            wait_ticks(10);
            rx = 1'b1;
            wait_ticks(6);
        end
        rx = 1'b1;
        wait_ticks(16);
    endtask

    task automatic check_frame(input string name, input logic [7:0] exp_dout,
                               input bit exp_ferr, input bit exp_perr);
        rec_t r;
        check({name, " done count"}, got.size(), 1);
        if (got.size() > 0) r = got.pop_front();
        else r = '{8'hxx, 1'bx, 1'bx};
        check({name, " rx_dout"}, {24'd0, r.dout}, {24'd0, exp_dout});
        check({name, " frame_err"}, {31'd0, r.ferr}, {31'd0, exp_ferr});
        check({name, " parity_err"}, {31'd0, r.perr}, {31'd0, exp_perr});
        got.delete();
    endtask

    initial begin
        vecs.push_back('{8'h55, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0});
        vecs.push_back('{8'hA3, 1'b1, 1'b0, 8'hA3, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0});
        vecs.push_back('{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1});
`endif
        vecs.push_back('{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0});
        vecs.push_back('{8'h81, 1'b1, 1'b0, 8'h81, 1'b0, 1'b0});

        // Reset
        rx      = 1'b1;
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        check("reset rx_dout", {24'd0, rx_dout}, 32'd0);
        check("reset rx_done_tick", {31'd0, rx_done_tick}, 32'd0);
        check("reset frame_err", {31'd0, frame_err}, 32'd0);
        check("reset parity_err", {31'd0, parity_err}, 32'd0);
        reset_n = 1'b1;
        wait_ticks(16);
        got.delete();

        // Frame table
        foreach (vecs[i]) begin
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].pflip);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_ferr,
                        vecs[i].exp_perr);
        end

        // A 200-clk low glitch while idle must not produce a frame.
        rx = 1'b0;
        repeat (200) @(negedge clk);
        rx = 1'b1;
        wait_ticks(32);
        check("glitch done count", got.size(), 0);
        check("glitch rx_dout held", {24'd0, rx_dout}, 32'h81);
        got.delete();

        // Reset for one clk during bit 4 of 0x96
        rx = 1'b0;
        wait_ticks(16);
        for (int k = 0; k < 4; k++) begin
            rx = 8'h96 >> k;
            wait_ticks(16);
        end
        rx = 1'b1;  // bit 4 of 0x96
        wait_ticks(8);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midreset rx_dout", {24'd0, rx_dout}, 32'd0);
        check("midreset frame_err", {31'd0, frame_err}, 32'd0);
        check("midreset parity_err", {31'd0, parity_err}, 32'd0);
        wait_ticks(16 * 12);
        check("midreset done count", got.size(), 0);
        check("midreset rx_dout idle", {24'd0, rx_dout}, 32'd0);
        got.delete();
        send_frame(8'h96, 1'b1, 1'b0);
        check_frame("after reset 0x96", 8'h96, 1'b0, 1'b0);

        // Break: three full frames complete, then the line is released while
        // the fourth frame is still in the start state.
        rx = 1'b0;
        wait_ticks(3 * FRAME_TICKS + 5);
        rx = 1'b1;
        wait_ticks(2);
        check("break done count", got.size(), 3);
        while (got.size() > 0) begin
            rec_t r;
            r = got.pop_front();
            check("break rx_dout", {24'd0, r.dout}, 32'd0);
            check("break frame_err", {31'd0, r.ferr}, 32'd1);
        end
        wait_ticks(32);
        check("break release done count", got.size(), 0);
        got.delete();
        send_frame(8'h5A, 1'b1, 1'b0);
        check_frame("after break 0x5A", 8'h5A, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
